// File: rtl/snap_capture_ctrl_if.sv
// Write-only BRAM port A bus from the snapshot capture controller.
// bram_we qualifies bram_addr/bram_wr_data each cycle; the BRAM has no backpressure.
interface snap_capture_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13
);
  logic              bram_we;
  logic              bram_en_a;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wr_data;

  modport master (output bram_we, bram_en_a, bram_addr, bram_wr_data);
  modport slave  (input  bram_we, bram_en_a, bram_addr, bram_wr_data);
endinterface

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arm/trigger, one-shot or circular pre-trigger capture
// into port A of a snapshot BRAM, with registered status for software readback.
module snap_capture_ctrl #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                circ,
  input  logic [ADDR_W-1:0]   post_len,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  input  logic                trig,
  snap_capture_ctrl_if.master bram,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W:0]     wr_count,
  output logic [2:0]          fsm_state
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST  = {1'b0, {ADDR_W{1'b1}}};

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              circ_q, circ_nxt;
  logic [ADDR_W-1:0] post_q, post_nxt;
  logic [ADDR_W-1:0] post_left, left_nxt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              busy_nxt, done_nxt;
  logic [ADDR_W-1:0] trig_addr_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              take;

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    circ_nxt      = circ_q;
    post_nxt      = post_q;
    left_nxt      = post_left;
    we_nxt        = 1'b0;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    done_nxt      = done;
    trig_addr_nxt = trig_addr;
    count_nxt     = wr_count;
    take          = 1'b0;

    if (arm) begin
      state_nxt     = S_WAIT;
      ptr_nxt       = '0;
      count_nxt     = '0;
      done_nxt      = 1'b0;
      trig_addr_nxt = '0;
      circ_nxt      = circ;
      // post_len is ADDR_W bits wide, so it can never exceed DEPTH-1 and the
      // trigger word is never overwritten by the post-trigger tail.
      post_nxt      = post_len;
    end else if (din_valid) begin
      case (state)
        S_WAIT: begin
          if (circ_q) begin
            take = 1'b1;
            if (trig) begin
              trig_addr_nxt = ptr;
              if (post_q == '0) begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
              end else begin
                state_nxt = S_POST;
                left_nxt  = post_q;
              end
            end
          end else if (trig) begin
            take          = 1'b1;
            trig_addr_nxt = ptr;
            if (wr_count == LAST) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          take = 1'b1;
          if (wr_count == LAST) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
        S_POST: begin
          take     = 1'b1;
          left_nxt = post_left - ADDR_W'(1);
          if (post_left == ADDR_W'(1)) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (take) begin
      we_nxt   = 1'b1;
      addr_nxt = ptr;
      data_nxt = din;
      ptr_nxt  = ptr + ADDR_W'(1);
      if (wr_count != DEPTH) count_nxt = wr_count + (ADDR_W+1)'(1);
    end

    busy_nxt = (state_nxt == S_WAIT) || (state_nxt == S_CAPTURE) || (state_nxt == S_POST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      circ_q    <= 1'b0;
      post_q    <= '0;
      post_left <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      trig_addr <= '0;
      wr_count  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      circ_q    <= circ_nxt;
      post_q    <= post_nxt;
      post_left <= left_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      trig_addr <= trig_addr_nxt;
      wr_count  <= count_nxt;
    end
  end

  assign bram.bram_we      = we_q;
  assign bram.bram_en_a    = we_q;
  assign bram.bram_addr    = addr_q;
  assign bram.bram_wr_data = data_q;
  assign fsm_state         = state;
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Bench for snap_capture_ctrl: default-size instance for the long capture sequences,
// a 16-word instance for the vector table, clamp case and randomized model check.
module tb_snap_capture_ctrl;
  localparam int DW = 128;
  localparam int AW = 13;
  localparam int DEPTH = 8192;
  localparam int SDW = 32;
  localparam int SAW = 4;
  localparam int SDEPTH = 16;
  localparam logic [2:0] ST_WAIT = 3'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // ---------------- large instance ----------------
  logic          b_rst_n, b_arm, b_circ, b_dv, b_trig;
  logic [AW-1:0] b_post;
  logic [DW-1:0] b_din;
  logic          b_busy, b_done;
  logic [AW-1:0] b_ta;
  logic [AW:0]   b_cnt;
  logic [2:0]    b_state;
  snap_capture_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

  snap_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(b_rst_n), .arm(b_arm), .circ(b_circ), .post_len(b_post),
    .din(b_din), .din_valid(b_dv), .trig(b_trig), .bram(b_if),
    .busy(b_busy), .done(b_done), .trig_addr(b_ta), .wr_count(b_cnt), .fsm_state(b_state)
  );

  // ---------------- small instance ----------------
  logic           s_rst_n, s_arm, s_circ, s_dv, s_trig;
  logic [SAW-1:0] s_post;
  logic [SDW-1:0] s_din;
  logic           s_busy, s_done;
  logic [SAW-1:0] s_ta;
  logic [SAW:0]   s_cnt;
  logic [2:0]     s_state;
  snap_capture_ctrl_if #(.DATA_W(SDW), .ADDR_W(SAW)) s_if ();

  snap_capture_ctrl #(.DATA_W(SDW), .ADDR_W(SAW)) dut_s (
    .clk(clk), .rst_n(s_rst_n), .arm(s_arm), .circ(s_circ), .post_len(s_post),
    .din(s_din), .din_valid(s_dv), .trig(s_trig), .bram(s_if),
    .busy(s_busy), .done(s_done), .trig_addr(s_ta), .wr_count(s_cnt), .fsm_state(s_state)
  );

  // ---------------- driver / scoreboard helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic b_set(input logic dv, input logic tg, input logic [DW-1:0] d);
    b_dv = dv; b_trig = tg; b_din = d;
  endtask

  task automatic b_arm_it(input logic c, input logic [AW-1:0] p);
    b_arm = 1'b1; b_circ = c; b_post = p; b_dv = 1'b0; b_trig = 1'b0;
    tick();
    b_arm = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           rst_n, arm, circ;
    logic [SAW-1:0] post_len;
    logic           dv, trig;
    logic [SDW-1:0] din;
    logic           e_we;
    logic [SAW-1:0] e_addr;
    logic [SDW-1:0] e_data;
    logic           e_done, e_busy;
    logic [SAW:0]   e_cnt;
    logic [SAW-1:0] e_ta;
  } vec_t;

  vec_t vecs[13];

  // ---------------- reference model (small instance) ----------------
  bit          m_armed, m_circ, m_trig_seen, m_fin;
  int          m_post, m_n, m_trig_n, m_after;
  logic        m_we;
  int          m_addr;
  logic [SDW-1:0] m_data;

  task automatic model_step(input logic rst, input logic a, input logic c, input int p,
                            input logic dv, input logic tg, input logic [SDW-1:0] d);
    if (!rst) begin
      m_armed = 0; m_circ = 0; m_trig_seen = 0; m_fin = 0;
      m_post = 0; m_n = 0; m_trig_n = 0; m_after = 0;
      m_we = 0; m_addr = 0; m_data = '0;
    end else if (a) begin
      m_armed = 1; m_circ = c; m_post = p; m_trig_seen = 0; m_fin = 0;
      m_n = 0; m_trig_n = 0; m_after = 0; m_we = 0;
    end else begin
      m_we = 0;
      if (m_armed && !m_fin && dv && (m_circ || m_trig_seen || tg)) begin
        m_we = 1; m_addr = m_n % SDEPTH; m_data = d; m_n++;
        if (!m_trig_seen && tg) begin
          m_trig_seen = 1; m_trig_n = m_n - 1;
          if (m_circ && m_post == 0) m_fin = 1;
        end else if (m_trig_seen && m_circ) begin
          m_after++;
          if (m_after == m_post) m_fin = 1;
        end
        if (!m_circ && m_n == SDEPTH) m_fin = 1;
      end
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_we"},   s_if.bram_we, m_we);
    chk({tag, "_en"},   s_if.bram_en_a, m_we);
    chk({tag, "_addr"}, s_if.bram_addr, m_addr);
    chk({tag, "_data"}, s_if.bram_wr_data, m_data);
    chk({tag, "_done"}, s_done, m_armed && m_fin);
    chk({tag, "_busy"}, s_busy, m_armed && !m_fin);
    chk({tag, "_cnt"},  s_cnt, (m_n > SDEPTH) ? SDEPTH : m_n);
    chk({tag, "_ta"},   s_ta, m_trig_n % SDEPTH);
  endtask

  logic [SDW-1:0] s_mem [SDEPTH];
  always @(posedge clk) if (s_if.bram_we) s_mem[s_if.bram_addr] <= s_if.bram_wr_data;

  // ---------------- test sequence ----------------
  initial begin
    b_rst_n = 1'b0; b_arm = 1'b0; b_circ = 1'b0; b_post = '0; b_set(1'b0, 1'b0, '0);
    s_rst_n = 1'b0; s_arm = 1'b0; s_circ = 1'b0; s_post = '0; s_dv = 1'b0; s_trig = 1'b0; s_din = '0;

    // rst, arm, circ, post, dv, trig, din | we, addr, data, done, busy, cnt, ta
    vecs[0]  = '{0,0,0,0,0,0,0,       0,0,0,0,0,0,0};
    vecs[1]  = '{1,1,1,2,1,1,'h11,    0,0,0,0,1,0,0};
    vecs[2]  = '{1,0,0,0,1,0,'h20,    1,0,'h20,0,1,1,0};
    vecs[3]  = '{1,0,0,0,0,0,'h99,    0,0,'h20,0,1,1,0};
    vecs[4]  = '{1,0,0,0,1,1,'h21,    1,1,'h21,0,1,2,1};
    vecs[5]  = '{1,0,0,0,1,1,'h22,    1,2,'h22,0,1,3,1};
    vecs[6]  = '{1,0,0,0,1,0,'h23,    1,3,'h23,1,0,4,1};
    vecs[7]  = '{1,0,0,0,1,1,'h24,    0,3,'h23,1,0,4,1};
    vecs[8]  = '{1,1,0,0,0,0,0,       0,3,'h23,0,1,0,0};
    vecs[9]  = '{1,0,0,0,1,0,'h25,    0,3,'h23,0,1,0,0};
    vecs[10] = '{1,0,1,0,1,1,'h30,    1,0,'h30,0,1,1,0};
    vecs[11] = '{1,0,0,0,1,0,'h31,    1,1,'h31,0,1,2,0};
    vecs[12] = '{0,0,0,0,1,1,'h32,    0,0,0,0,0,0,0};

    for (int i = 0; i < 13; i++) begin
      s_rst_n = vecs[i].rst_n; s_arm = vecs[i].arm; s_circ = vecs[i].circ;
      s_post = vecs[i].post_len; s_dv = vecs[i].dv; s_trig = vecs[i].trig; s_din = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_we", i),   s_if.bram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_addr", i), s_if.bram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_data", i), s_if.bram_wr_data, vecs[i].e_data);
      chk($sformatf("vec%0d_done", i), s_done, vecs[i].e_done);
      chk($sformatf("vec%0d_busy", i), s_busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_cnt", i),  s_cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d_ta", i),   s_ta, vecs[i].e_ta);
    end
    s_rst_n = 1'b1; s_arm = 1'b0; s_dv = 1'b0; s_trig = 1'b0;

    // large instance: reset state
    tick();
    chk("rst_we", b_if.bram_we, 0);
    chk("rst_en", b_if.bram_en_a, 0);
    chk("rst_addr", b_if.bram_addr, 0);
    chk("rst_data", b_if.bram_wr_data, 0);
    chk("rst_done", b_done, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_cnt", b_cnt, 0);
    chk("rst_ta", b_ta, 0);
    b_rst_n = 1'b1;

    // one-shot: no writes before trigger, then DEPTH words from address 0
    b_arm_it(1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      b_set(1'b1, 1'b0, DW'(i + 1000));
      tick();
      chk("os_wait_we", b_if.bram_we, 0);
    end
    b_set(1'b1, 1'b1, DW'('hA5));
    tick();
    chk("os_trig_we", b_if.bram_we, 1);
    chk("os_trig_addr", b_if.bram_addr, 0);
    chk("os_trig_data", b_if.bram_wr_data, 'hA5);
    chk("os_trig_ta", b_ta, 0);
    for (int k = 1; k < DEPTH; k++) begin
      b_set(1'b1, 1'b0, DW'(k));
      tick();
      chk("os_we", b_if.bram_we, 1);
      chk("os_addr", b_if.bram_addr, k);
      chk("os_done", b_done, k == DEPTH - 1);
    end
    chk("os_end_cnt", b_cnt, DEPTH);
    chk("os_end_busy", b_busy, 0);
    tick();
    chk("os_after_we", b_if.bram_we, 0);
    chk("os_after_done", b_done, 1);
    chk("os_after_cnt", b_cnt, DEPTH);

    // circular, post_len=4, trigger on word index 8999
    b_arm_it(1'b1, AW'(4));
    for (int i = 0; i < 10000; i++) begin
      b_set(1'b1, i == 8999, DW'(i));
      tick();
      chk("circ_we", b_if.bram_we, i <= 9003);
      if (i <= 9003) chk("circ_addr", b_if.bram_addr, i % DEPTH);
      chk("circ_done", b_done, i >= 9003);
      chk("circ_busy", b_busy, i < 9003);
    end
    chk("circ_ta", b_ta, 807);
    chk("circ_last_addr", b_if.bram_addr, 811);
    chk("circ_cnt", b_cnt, DEPTH);

    // circular, post_len=0, trigger on the third word
    b_arm_it(1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      b_set(1'b1, i == 2, DW'(i + 50));
      tick();
      chk("c0_we", b_if.bram_we, 1);
      chk("c0_done", b_done, i == 2);
    end
    chk("c0_ta", b_ta, 2);
    chk("c0_cnt", b_cnt, 3);
    b_set(1'b1, 1'b0, '0);
    tick();
    chk("c0_after_we", b_if.bram_we, 0);

    // one-shot with din_valid toggling every cycle
    begin
      int w = 0;
      b_arm_it(1'b0, '0);
      for (int c = 0; c < 2 * DEPTH + 2; c++) begin
        b_set((c % 2) == 0, c == 0, DW'(c));
        tick();
        if ((c % 2) == 0 && w < DEPTH) begin
          chk("tog_we", b_if.bram_we, 1);
          chk("tog_addr", b_if.bram_addr, w);
          w++;
        end else begin
          chk("tog_idle_we", b_if.bram_we, 0);
        end
        chk("tog_done", b_done, w == DEPTH);
      end
      chk("tog_cnt", b_cnt, DEPTH);
    end

    // reset in POST with two words remaining
    b_arm_it(1'b1, AW'(5));
    b_set(1'b1, 1'b1, DW'('h77));
    tick();
    for (int i = 0; i < 3; i++) begin
      b_set(1'b1, 1'b0, DW'(i));
      tick();
    end
    chk("post_pre_rst_busy", b_busy, 1);
    b_rst_n = 1'b0;
    tick();
    chk("midrst_we", b_if.bram_we, 0);
    chk("midrst_addr", b_if.bram_addr, 0);
    chk("midrst_data", b_if.bram_wr_data, 0);
    chk("midrst_done", b_done, 0);
    chk("midrst_busy", b_busy, 0);
    chk("midrst_cnt", b_cnt, 0);
    chk("midrst_ta", b_ta, 0);
    b_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_set(1'b1, 1'b1, DW'(i));
      tick();
      chk("postrst_we", b_if.bram_we, 0);
      chk("postrst_busy", b_busy, 0);
    end

    // re-arm in the middle of a one-shot capture; arm beats a coincident trigger
    b_arm_it(1'b0, '0);
    b_set(1'b1, 1'b1, DW'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      b_set(1'b1, 1'b0, DW'(i));
      tick();
    end
    chk("rearm_pre_cnt", b_cnt, 4);
    b_arm = 1'b1; b_circ = 1'b0; b_set(1'b1, 1'b1, DW'(9));
    tick();
    b_arm = 1'b0;
    chk("rearm_we", b_if.bram_we, 0);
    chk("rearm_cnt", b_cnt, 0);
    chk("rearm_done", b_done, 0);
    chk("rearm_busy", b_busy, 1);
    chk("rearm_state", b_state, ST_WAIT);
    chk("rearm_ta", b_ta, 0);

    // small instance: largest post_len keeps the trigger word intact
    s_arm = 1'b1; s_circ = 1'b1; s_post = SAW'(8191);
    tick();
    s_arm = 1'b0;
    for (int i = 0; i < 21; i++) begin
      s_dv = 1'b1; s_trig = (i == 5); s_din = (i == 5) ? SDW'('hBEEF) : SDW'(i);
      tick();
      chk("clamp_done", s_done, i == 20);
    end
    s_dv = 1'b0; s_trig = 1'b0;
    tick();
    chk("clamp_ta", s_ta, 5);
    chk("clamp_last_addr", s_if.bram_addr, 4);
    chk("clamp_cnt", s_cnt, SDEPTH);
    chk("clamp_trig_word", s_mem[5], 'hBEEF);

    // randomized stimulus against the reference model
    s_rst_n = 1'b0; s_arm = 1'b0; s_dv = 1'b0; s_trig = 1'b0;
    tick();
    model_step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, '0);
    model_check("rnd_rst");
    for (int i = 0; i < 4000; i++) begin
      s_rst_n = ($urandom_range(0, 599) != 0);
      s_arm   = ($urandom_range(0, 39) == 0);
      s_circ  = $urandom_range(0, 1);
      s_post  = SAW'($urandom_range(0, SDEPTH - 1));
      s_dv    = ($urandom_range(0, 9) < 7);
      s_trig  = ($urandom_range(0, 19) == 0);
      s_din   = $urandom;
      tick();
      model_step(s_rst_n, s_arm, s_circ, s_post, s_dv, s_trig, s_din);
      model_check("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
